// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong controller for two line-height RAM banks: the writer fills the back bank while
// the scan reads the front bank; banks swap on frame_start once the back bank is complete.
module pingpong_frame_ctrl #(
  parameter int DEPTH  = 160,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              bank0_we,
  output logic              bank1_we,
  output logic [ADDR_W-1:0] bank0_addr,
  output logic [ADDR_W-1:0] bank1_addr,
  output logic [DATA_W-1:0] bank0_wdata,
  output logic [DATA_W-1:0] bank1_wdata,
  input  logic [DATA_W-1:0] bank0_q,
  input  logic [DATA_W-1:0] bank1_q,
  output logic              front_sel,
  output logic              swap_pulse,
  output logic [7:0]        drop_cnt,
  output logic              dbg_wr_state
);

  // Write handshake: a write is accepted on a rising edge where wr_valid && wr_ready.
  // wr_ready is registered and is high exactly while the writer is in W_FILL.
  typedef enum logic {W_FILL = 1'b0, W_DONE = 1'b1} wstate_e;

  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W + 1)'(DEPTH);

  wstate_e             wstate_q, wstate_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
  logic                front_sel_q, front_sel_d;
  logic                swap_q, swap_d;
  logic [7:0]          drop_q, drop_d;
  logic                wr_ready_q, wr_ready_d;
  logic                b0_we_q, b0_we_d, b1_we_q, b1_we_d;
  logic [ADDR_W-1:0]   b0_addr_q, b0_addr_d, b1_addr_q, b1_addr_d;
  logic [DATA_W-1:0]   b0_wdata_q, b0_wdata_d, b1_wdata_q, b1_wdata_d;
  logic                p1_valid_q, p1_valid_d, p1_sel_q, p1_sel_d;
  logic                p2_valid_q, p2_valid_d, p2_sel_q, p2_sel_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                wr_fire, rd_fire;

  always_comb begin
    wstate_d    = wstate_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    front_sel_d = front_sel_q;
    swap_d      = 1'b0;
    drop_d      = drop_q;
    b0_we_d     = 1'b0;
    b1_we_d     = 1'b0;
    b0_addr_d   = '0;
    b1_addr_d   = '0;
    b0_wdata_d  = '0;
    b1_wdata_d  = '0;

    wr_fire = wr_valid && wr_ready_q;
    rd_fire = rd_req && !frame_start && (rd_cnt_q < RD_END);

    if (wr_fire) begin
      if (front_sel_q) begin
        b0_we_d    = 1'b1;
        b0_addr_d  = wr_cnt_q;
        b0_wdata_d = wr_data;
      end else begin
        b1_we_d    = 1'b1;
        b1_addr_d  = wr_cnt_q;
        b1_wdata_d = wr_data;
      end
      if (wr_cnt_q == WR_LAST) begin
        wr_cnt_d = '0;
        wstate_d = W_DONE;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // Back bank is never the front bank, so a read and a write cannot share a bank.
    if (rd_fire) begin
      if (front_sel_q) b1_addr_d = rd_cnt_q[ADDR_W-1:0];
      else             b0_addr_d = rd_cnt_q[ADDR_W-1:0];
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    // Swap decision looks at the state before this cycle's write, so a last write
    // colliding with frame_start counts as a drop.
    if (frame_start) begin
      rd_cnt_d = '0;
      if (wstate_q == W_DONE) begin
        front_sel_d = ~front_sel_q;
        swap_d      = 1'b1;
        wstate_d    = W_FILL;
        wr_cnt_d    = '0;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    wr_ready_d = (wstate_d == W_FILL);

    // The bank select travels with each read so a mid-pipeline swap is harmless.
    p1_valid_d = rd_fire;
    p1_sel_d   = front_sel_q;
    p2_valid_d = p1_valid_q;
    p2_sel_d   = p1_sel_q;
    rd_valid_d = p2_valid_q;
    rd_data_d  = rd_data_q;
    if (p2_valid_q) rd_data_d = p2_sel_q ? bank1_q : bank0_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q    <= W_FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      front_sel_q <= 1'b0;
      swap_q      <= 1'b0;
      drop_q      <= '0;
      wr_ready_q  <= 1'b0;
      b0_we_q     <= 1'b0;
      b1_we_q     <= 1'b0;
      b0_addr_q   <= '0;
      b1_addr_q   <= '0;
      b0_wdata_q  <= '0;
      b1_wdata_q  <= '0;
      p1_valid_q  <= 1'b0;
      p1_sel_q    <= 1'b0;
      p2_valid_q  <= 1'b0;
      p2_sel_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wstate_q    <= wstate_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      front_sel_q <= front_sel_d;
      swap_q      <= swap_d;
      drop_q      <= drop_d;
      wr_ready_q  <= wr_ready_d;
      b0_we_q     <= b0_we_d;
      b1_we_q     <= b1_we_d;
      b0_addr_q   <= b0_addr_d;
      b1_addr_q   <= b1_addr_d;
      b0_wdata_q  <= b0_wdata_d;
      b1_wdata_q  <= b1_wdata_d;
      p1_valid_q  <= p1_valid_d;
      p1_sel_q    <= p1_sel_d;
      p2_valid_q  <= p2_valid_d;
      p2_sel_q    <= p2_sel_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign bank0_we     = b0_we_q;
  assign bank1_we     = b1_we_q;
  assign bank0_addr   = b0_addr_q;
  assign bank1_addr   = b1_addr_q;
  assign bank0_wdata  = b0_wdata_q;
  assign bank1_wdata  = b1_wdata_q;
  assign front_sel    = front_sel_q;
  assign swap_pulse   = swap_q;
  assign drop_cnt     = drop_q;
  assign dbg_wr_state = wstate_q;

endmodule

// File: doc/pingpong_frame_ctrl.md
# pingpong_frame_ctrl

Ping-pong controller for the two line-height RAM banks in the game display path. It sequences the banks so the playfield generator fills the back bank while the VGA scan reads the front bank. The banks swap only at a frame boundary, and only once the back bank holds a complete frame. The block sits between the y-position generator (write side), the two single-port RAM banks, and the VGA output register (read side).

## Interface
- DEPTH, 160, entries per frame (columns); 2..256
- ADDR_W, 8, RAM address width
- DATA_W, 8, y value width
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse from VGA timing at start of each frame
- wr_valid  in  1  writer has a y value
- wr_data  in  DATA_W  y value to store
- wr_ready  out  1  controller accepts a write this cycle
- rd_req  in  1  scan requests next column value
- rd_data  out  DATA_W  value read from front bank
- rd_valid  out  1  rd_data valid this cycle
- bank0_we, bank1_we  out  1  registered write enables
- bank0_addr, bank1_addr  out  ADDR_W  registered addresses
- bank0_wdata, bank1_wdata  out  DATA_W  registered write data
- bank0_q, bank1_q  in  DATA_W  RAM read data, valid one cycle after address
- front_sel  out  1  0: bank0 is front, 1: bank1 is front
- swap_pulse  out  1  one-cycle pulse on each swap
- drop_cnt  out  8  frames where swap was skipped; saturates at 255

## Operation
- Back bank = ~front_sel. Writes go only to the back bank. Reads go only to the front bank.
- Writer FSM states: W_FILL, W_DONE.
  - W_FILL: wr_ready=1. Handshake is wr_valid & wr_ready.
    - Each accepted write registers we=1, addr=wr_cnt, wdata=wr_data on the back bank, then increments wr_cnt.
    - The accepted write at wr_cnt=DEPTH-1 moves the FSM to W_DONE and clears wr_cnt to 0.
  - W_DONE: wr_ready=0. Writes are ignored.
- Swap rule on frame_start uses the writer state at the start of the cycle.
  - If the state is W_DONE: toggle front_sel, assert swap_pulse, move to W_FILL (new back bank), clear rd_cnt.
  - If the state is W_FILL: no toggle, drop_cnt += 1 (saturating), rd_cnt cleared, writer keeps filling at its current wr_cnt.
- If the last write and frame_start occur in the same cycle, the write is accepted and the FSM enters W_DONE. There is no swap that frame and drop_cnt increments. The swap happens on the next frame_start.
- Read side: rd_cnt counts 0..DEPTH-1.
  - rd_req with rd_cnt<DEPTH registers the front-bank address = rd_cnt, then increments rd_cnt.
  - rd_req with rd_cnt=DEPTH is ignored, and no rd_valid is produced.
  - rd_req in the same cycle as frame_start is ignored.
- The bank select is pipelined with each read. A swap mid-pipeline still returns data from the bank that was addressed.
- Unused bank address/we lines hold addr=0, we=0.

## Timing
- Reset (async, any time, including mid-write or mid-read) forces:
  - front_sel=0, writer state W_FILL, wr_cnt=0, rd_cnt=0
  - wr_ready=0, rd_valid=0, rd_data=0, swap_pulse=0, drop_cnt=0
  - all bank we/addr/wdata=0; read pipeline flushed
- wr_ready rises on the first rising edge after resetn deasserts.
- Write: handshake at edge T; bank we/addr/wdata are valid from T to T+1; the RAM captures at T+1.
- Read: rd_req sampled at edge T; address driven from T; bank q is valid after T+1; rd_data registered at T+2. rd_valid is high for exactly one cycle, T+2..T+3.
- Back-to-back rd_req on consecutive cycles yields rd_valid on consecutive cycles (throughput 1/cycle).
- front_sel and swap_pulse change at the edge that samples frame_start.
- wr_ready drops in the cycle after the final accepted write.

## Test plan
- Reset then fill:
  - Stimulus: release resetn; hold wr_valid=1 with wr_data=i for i=0..159.
  - Required: exactly 160 bank1_we pulses at addr 0..159; wr_ready=0 afterward; front_sel stays 0.
- Swap:
  - Stimulus: after the full fill, pulse frame_start.
  - Required: front_sel=1 and swap_pulse=1 for one cycle; wr_ready=1 next cycle; subsequent writes go to bank0.
- Read latency:
  - Stimulus: after the swap, rd_req for 3 consecutive cycles; bank1_q models the RAM contents.
  - Required: rd_valid for 3 consecutive cycles starting 2 cycles after the first rd_req; rd_data=0,1,2.
- Drop:
  - Stimulus: frame_start after only 50 writes.
  - Required: front_sel unchanged; drop_cnt=1; the next write goes to addr 50; rd_cnt restarts at 0.
- Collision:
  - Stimulus: frame_start in the same cycle as the write at addr 159.
  - Required: write accepted, no swap, drop_cnt increments; the next frame_start swaps.
- Mid-operation reset:
  - Stimulus: assert resetn low between clock edges during an active read and write.
  - Required: all outputs zero immediately; no rd_valid emitted from the flushed pipeline.
